// File: rtl/stage_id_pkg.sv
// -----------------------------------------------------------------------------
// stage_id_pkg
// Shared definitions for the MIPS32 instruction-decode stage:
//   - opcode / funct constants for the decoded subset
//   - ALUOp encodings handed to the execute stage
//   - instruction-class codes used for pipeline display
//   - control bundle and IF/ID register layout
//   - decode() helper mapping an instruction word to its control bundle
// -----------------------------------------------------------------------------
package stage_id_pkg;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        INST_TYPE_NONE   = 4'd0,
        INST_TYPE_R      = 4'd1,
        INST_TYPE_I      = 4'd2,
        INST_TYPE_LOAD   = 4'd3,
        INST_TYPE_STORE  = 4'd4,
        INST_TYPE_BRANCH = 4'd5
    } inst_type_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        alu_op_e    alu_op;
        inst_type_e inst_type;
    } ctrl_t;

    // All-zero bundle: no side effects, class NONE. Used for NOPs and bubbles.
    localparam ctrl_t CTRL_NONE = '0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] new_pc;
        logic [3:0]  inst_num;
    } ifid_t;

    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t c;
        c = CTRL_NONE;
        case (inst[31:26])
            OP_RTYPE: begin
                // Only the supported functs decode; everything else (incl. the
                // all-zero NOP) stays a no-op.
                if (inst[5:0] inside {FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT}) begin
                    c.reg_dst   = 1'b1;
                    c.reg_write = 1'b1;
                    c.alu_op    = ALUOP_FUNCT;
                    c.inst_type = INST_TYPE_R;
                end
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
                c.inst_type = INST_TYPE_I;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_op     = ALUOP_ADD;
                c.inst_type  = INST_TYPE_LOAD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
                c.inst_type = INST_TYPE_STORE;
            end
            OP_BEQ: begin
                c.branch    = 1'b1;
                c.alu_op    = ALUOP_SUB;
                c.inst_type = INST_TYPE_BRANCH;
            end
            default: ;
        endcase
        return c;
    endfunction

    // rt is read as an operand (not a destination) by these classes.
    function automatic logic rt_is_source(input inst_type_e t);
        return (t == INST_TYPE_R) || (t == INST_TYPE_STORE) || (t == INST_TYPE_BRANCH);
    endfunction

endpackage

// File: rtl/stage_id_register_file.sv
// -----------------------------------------------------------------------------
// stage_id_register_file
// Architectural register file: two combinational read ports, one write port.
// Register 0 always reads 0 and ignores writes. A write and a read of the same
// register in one cycle returns the data being written (write-through bypass).
// Ports:
//   clock, reset          synchronous active-high reset clears every register
//   we_i, waddr_i, wdata_i write port, committed on the rising edge
//   raddr1_i / rdata1_o   read port 1 (rs)
//   raddr2_i / rdata2_o   read port 2 (rt)
// -----------------------------------------------------------------------------
module stage_id_register_file #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        raddr1_i,
    input  logic [4:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic              wr_en;

    // A write-back coinciding with reset is dropped, both from the array and
    // from the bypass path.
    assign wr_en = we_i && (waddr_i != 5'd0) && !reset;

    // NOTE: the array is cleared on reset because software may read any
    // register before writing it and must see 0; that reset also prevents the
    // array from being inferred as a plain RAM block.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        if (raddr1_i == 5'd0)                    rdata1_o = '0;
        else if (wr_en && waddr_i == raddr1_i)   rdata1_o = wdata_i;
        else                                     rdata1_o = regs_q[raddr1_i];

        if (raddr2_i == 5'd0)                    rdata2_o = '0;
        else if (wr_en && waddr_i == raddr2_i)   rdata2_o = wdata_i;
        else                                     rdata2_o = regs_q[raddr2_i];
    end

endmodule

// File: rtl/stage_id.sv
// -----------------------------------------------------------------------------
// stage_id
// Instruction-decode stage of the five-stage MIPS32 pipeline.
// Holds the IF/ID register, decodes the held instruction, reads the register
// file, detects load-use hazards and drives the ID/EX register.
// Ports:
//   clock, reset                 synchronous active-high reset
//   IF_PC/IF_NewPC/IF_Inst/IF_InstNum  fetched instruction and its context
//   WB_RegWrite/WB_WriteReg/WB_WriteData  register-file write-back
//   EX_MemRead/EX_Rt             load currently in EX, for hazard detection
//   Flush                        kill IF/ID and ID/EX (taken branch)
//   ID_Stall                     combinational; fetch holds PC while high
//   PR_IDEX_*, CS_*              ID/EX pipeline register contents
// -----------------------------------------------------------------------------
module stage_id
    import stage_id_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       IF_PC,
    input  logic [31:0]       IF_NewPC,
    input  logic [31:0]       IF_Inst,
    input  logic [3:0]        IF_InstNum,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WriteReg,
    input  logic [DATA_W-1:0] WB_WriteData,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_Rt,
    input  logic              Flush,
    output logic              ID_Stall,
    output logic [31:0]       PR_IDEX_NewPC,
    output logic [DATA_W-1:0] PR_IDEX_ReadData1,
    output logic [DATA_W-1:0] PR_IDEX_ReadData2,
    output logic [DATA_W-1:0] PR_IDEX_Imm,
    output logic [4:0]        PR_IDEX_Rs,
    output logic [4:0]        PR_IDEX_Rt,
    output logic [4:0]        PR_IDEX_Rd,
    output logic [5:0]        PR_IDEX_Funct,
    output logic              CS_RegDst,
    output logic              CS_ALUSrc,
    output logic              CS_MemRead,
    output logic              CS_MemWrite,
    output logic              CS_MemToReg,
    output logic              CS_RegWrite,
    output logic              CS_Branch,
    output logic [1:0]        CS_ALUOp,
    output logic [3:0]        PR_IDEX_InstType,
    output logic [3:0]        PR_IDEX_InstNum
);

    // The word address itself is not needed downstream; only PC+1 travels on.
    logic unused_if_pc;
    assign unused_if_pc = ^IF_PC;

    // ---------------- IF/ID register and decode ----------------
    ifid_t ifid_q, ifid_d;

    logic [4:0] rs, rt, rd;
    ctrl_t      dec;

    assign rs  = ifid_q.inst[25:21];
    assign rt  = ifid_q.inst[20:16];
    assign rd  = ifid_q.inst[15:11];
    assign dec = decode(ifid_q.inst);

    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

    stage_id_register_file #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W)
    ) u_register_file (
        .clock    (clock),
        .reset    (reset),
        .we_i     (WB_RegWrite),
        .waddr_i  (WB_WriteReg),
        .wdata_i  (WB_WriteData),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // ---------------- load-use hazard ----------------
    // An empty IF/ID holds the all-zero NOP, so rs = rt = 0 and EX_Rt != 0
    // keeps the stall low without a separate valid bit.
    logic hazard;
    logic bubble;

    assign hazard = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == rs) || ((EX_Rt == rt) && rt_is_source(dec.inst_type)));
    assign ID_Stall = hazard && !Flush;
    assign bubble   = Flush || hazard;

    // ---------------- ID/EX register ----------------
    ctrl_t             ctrl_q,  ctrl_d;
    logic [31:0]       newpc_q, newpc_d;
    logic [DATA_W-1:0] rd1_q,   rd1_d;
    logic [DATA_W-1:0] rd2_q,   rd2_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [4:0]        rs_q,    rs_d;
    logic [4:0]        rt_q,    rt_d;
    logic [4:0]        rd_q,    rd_d;
    logic [5:0]        funct_q, funct_d;
    logic [3:0]        num_q,   num_d;

    // NOTE: every signal driven here gets its default on the first lines of
    // the block, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        ifid_d  = ifid_q;
        ctrl_d  = CTRL_NONE;
        newpc_d = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        funct_d = '0;
        // The sequence number rides through bubbles so the next real
        // instruction keeps its own number.
        num_d   = ifid_q.inst_num;

        if (Flush) begin
            ifid_d          = '0;
            ifid_d.inst_num = IF_InstNum;
        end else if (!hazard) begin
            ifid_d.inst     = IF_Inst;
            ifid_d.new_pc   = IF_NewPC;
            ifid_d.inst_num = IF_InstNum;
        end

        if (!bubble) begin
            ctrl_d  = dec;
            newpc_d = ifid_q.new_pc;
            rd1_d   = rf_rdata1;
            rd2_d   = rf_rdata2;
            imm_d   = {{(DATA_W-16){ifid_q.inst[15]}}, ifid_q.inst[15:0]};
            rs_d    = rs;
            rt_d    = rt;
            rd_d    = rd;
            funct_d = ifid_q.inst[5:0];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifid_q  <= '0;
            ctrl_q  <= CTRL_NONE;
            newpc_q <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
            num_q   <= '0;
        end else begin
            ifid_q  <= ifid_d;
            ctrl_q  <= ctrl_d;
            newpc_q <= newpc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
            num_q   <= num_d;
        end
    end

    assign PR_IDEX_NewPC     = newpc_q;
    assign PR_IDEX_ReadData1 = rd1_q;
    assign PR_IDEX_ReadData2 = rd2_q;
    assign PR_IDEX_Imm       = imm_q;
    assign PR_IDEX_Rs        = rs_q;
    assign PR_IDEX_Rt        = rt_q;
    assign PR_IDEX_Rd        = rd_q;
    assign PR_IDEX_Funct     = funct_q;
    assign CS_RegDst         = ctrl_q.reg_dst;
    assign CS_ALUSrc         = ctrl_q.alu_src;
    assign CS_MemRead        = ctrl_q.mem_read;
    assign CS_MemWrite       = ctrl_q.mem_write;
    assign CS_MemToReg       = ctrl_q.mem_to_reg;
    assign CS_RegWrite       = ctrl_q.reg_write;
    assign CS_Branch         = ctrl_q.branch;
    assign CS_ALUOp          = ctrl_q.alu_op;
    assign PR_IDEX_InstType  = ctrl_q.inst_type;
    assign PR_IDEX_InstNum   = num_q;

endmodule

// File: tb/tb_stage_id.sv
// -----------------------------------------------------------------------------
// tb_stage_id
// Self-checking bench for stage_id: directed scenarios followed by a
// randomized run compared against a behavioural model of the decode stage.
// -----------------------------------------------------------------------------
module tb_stage_id;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IF_PC, IF_NewPC, IF_Inst;
    logic [3:0]  IF_InstNum;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        Flush;
    logic        ID_Stall;
    logic [31:0] PR_IDEX_NewPC, PR_IDEX_ReadData1, PR_IDEX_ReadData2, PR_IDEX_Imm;
    logic [4:0]  PR_IDEX_Rs, PR_IDEX_Rt, PR_IDEX_Rd;
    logic [5:0]  PR_IDEX_Funct;
    logic        CS_RegDst, CS_ALUSrc, CS_MemRead, CS_MemWrite, CS_MemToReg, CS_RegWrite, CS_Branch;
    logic [1:0]  CS_ALUOp;
    logic [3:0]  PR_IDEX_InstType, PR_IDEX_InstNum;

    int checks = 0;
    int fails  = 0;

    stage_id dut (
        .clock             (clock),
        .reset             (reset),
        .IF_PC             (IF_PC),
        .IF_NewPC          (IF_NewPC),
        .IF_Inst           (IF_Inst),
        .IF_InstNum        (IF_InstNum),
        .WB_RegWrite       (WB_RegWrite),
        .WB_WriteReg       (WB_WriteReg),
        .WB_WriteData      (WB_WriteData),
        .EX_MemRead        (EX_MemRead),
        .EX_Rt             (EX_Rt),
        .Flush             (Flush),
        .ID_Stall          (ID_Stall),
        .PR_IDEX_NewPC     (PR_IDEX_NewPC),
        .PR_IDEX_ReadData1 (PR_IDEX_ReadData1),
        .PR_IDEX_ReadData2 (PR_IDEX_ReadData2),
        .PR_IDEX_Imm       (PR_IDEX_Imm),
        .PR_IDEX_Rs        (PR_IDEX_Rs),
        .PR_IDEX_Rt        (PR_IDEX_Rt),
        .PR_IDEX_Rd        (PR_IDEX_Rd),
        .PR_IDEX_Funct     (PR_IDEX_Funct),
        .CS_RegDst         (CS_RegDst),
        .CS_ALUSrc         (CS_ALUSrc),
        .CS_MemRead        (CS_MemRead),
        .CS_MemWrite       (CS_MemWrite),
        .CS_MemToReg       (CS_MemToReg),
        .CS_RegWrite       (CS_RegWrite),
        .CS_Branch         (CS_Branch),
        .CS_ALUOp          (CS_ALUOp),
        .PR_IDEX_InstType  (PR_IDEX_InstType),
        .PR_IDEX_InstNum   (PR_IDEX_InstNum)
    );

    always #5 clock = ~clock;

    // Observation bundles.
    wire [8:0]   ctrl_o = {CS_RegDst, CS_ALUSrc, CS_MemRead, CS_MemWrite, CS_MemToReg,
                           CS_RegWrite, CS_Branch, CS_ALUOp};
    wire [161:0] idex_o = {PR_IDEX_NewPC, PR_IDEX_ReadData1, PR_IDEX_ReadData2, PR_IDEX_Imm,
                           PR_IDEX_Rs, PR_IDEX_Rt, PR_IDEX_Rd, PR_IDEX_Funct, ctrl_o, PR_IDEX_InstType};
    wire [166:0] all_o  = {idex_o, PR_IDEX_InstNum, ID_Stall};

    // ---------------- helpers (stimulus only) ----------------
    task automatic idle_inputs();
        IF_PC = '0; IF_NewPC = '0; IF_Inst = '0; IF_InstNum = '0;
        WB_RegWrite = 1'b0; WB_WriteReg = '0; WB_WriteData = '0;
        EX_MemRead = 1'b0; EX_Rt = '0; Flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] npc, input logic [3:0] num);
        IF_Inst = inst; IF_NewPC = npc; IF_PC = npc - 32'd1; IF_InstNum = num;
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        WB_RegWrite = we; WB_WriteReg = r; WB_WriteData = d;
    endtask

    // ---------------- reference model ----------------
    // Instruction class from the encoding: 0 NONE, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH.
    function automatic int classify(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) ? 1 : 0;
        if (op == 6'h08) return 2;
        if (op == 6'h23) return 3;
        if (op == 6'h2B) return 4;
        if (op == 6'h04) return 5;
        return 0;
    endfunction

    // {RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, Branch, ALUOp}
    function automatic logic [8:0] exp_ctrl(input int cls);
        case (cls)
            1: return 9'b1000010_10;
            2: return 9'b0100010_00;
            3: return 9'b0110110_00;
            4: return 9'b0101000_00;
            5: return 9'b0000001_01;
            default: return 9'b0000000_00;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0]  good_fn [5];
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        good_fn[0] = 6'h20; good_fn[1] = 6'h22; good_fn[2] = 6'h24;
        good_fn[3] = 6'h25; good_fn[4] = 6'h2A;
        a   = 5'($urandom_range(0, 7));
        b   = 5'($urandom_range(0, 7));
        c   = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return {6'h00, a, b, c, 5'd0, good_fn[$urandom_range(0, 4)]};
            1: return {6'h00, a, b, c, 5'($urandom), 6'($urandom)};
            2: return {6'h08, a, b, imm};
            3: return {6'h23, a, b, imm};
            4: return {6'h2B, a, b, imm};
            5: return {6'h04, a, b, imm};
            6: return $urandom;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (all_o !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", all_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        fetch(32'h2001FFFF, 32'h11, 4'd1);
        step();
        fetch(32'h0, 32'h12, 4'd2);
        step();
        checks++; if (PR_IDEX_Imm !== 32'hFFFFFFFF) begin fails++; $display("FAIL addi_imm got=%h exp=ffffffff", PR_IDEX_Imm); end
        checks++; if (PR_IDEX_Rt !== 5'd1) begin fails++; $display("FAIL addi_rt got=%0d exp=1", PR_IDEX_Rt); end
        checks++; if (ctrl_o !== 9'b0100010_00) begin fails++; $display("FAIL addi_ctrl got=%b exp=010001000", ctrl_o); end
        checks++; if (PR_IDEX_ReadData1 !== 32'h0) begin fails++; $display("FAIL addi_rd1 got=%h exp=0", PR_IDEX_ReadData1); end
        checks++; if (PR_IDEX_InstType !== 4'd2) begin fails++; $display("FAIL addi_type got=%0d exp=2", PR_IDEX_InstType); end
        checks++; if ({PR_IDEX_NewPC, PR_IDEX_InstNum} !== {32'h11, 4'd1}) begin
            fails++; $display("FAIL addi_pc_num got=%h/%0d exp=11/1", PR_IDEX_NewPC, PR_IDEX_InstNum);
        end
    endtask

    task automatic test_add_wb();
        wb(1'b1, 5'd1, 32'd5);
        fetch(32'h0, 32'h13, 4'd2);
        step();
        wb(1'b1, 5'd2, 32'd7);
        step();
        wb(1'b0, 5'd0, 32'd0);
        fetch(32'h00221820, 32'h14, 4'd3);
        step();
        fetch(32'h0, 32'h15, 4'd4);
        step();
        checks++; if ({PR_IDEX_ReadData1, PR_IDEX_ReadData2} !== {32'd5, 32'd7}) begin
            fails++; $display("FAIL add_operands got=%h/%h exp=5/7", PR_IDEX_ReadData1, PR_IDEX_ReadData2);
        end
        checks++; if ({PR_IDEX_Rd, PR_IDEX_Funct} !== {5'd3, 6'h20}) begin
            fails++; $display("FAIL add_rd_funct got=%0d/%h exp=3/20", PR_IDEX_Rd, PR_IDEX_Funct);
        end
        checks++; if (ctrl_o !== 9'b1000010_10) begin fails++; $display("FAIL add_ctrl got=%b exp=100001010", ctrl_o); end
        checks++; if ({PR_IDEX_InstType, PR_IDEX_InstNum} !== {4'd1, 4'd3}) begin
            fails++; $display("FAIL add_type_num got=%0d/%0d exp=1/3", PR_IDEX_InstType, PR_IDEX_InstNum);
        end
    endtask

    task automatic test_bypass();
        fetch(32'h00221820, 32'h16, 4'd4);       // ADD $3,$1,$2
        step();
        wb(1'b1, 5'd2, 32'h1234);                 // same cycle ID reads $2
        fetch(32'h00001820, 32'h17, 4'd5);        // ADD $3,$0,$0
        step();
        checks++; if ({PR_IDEX_ReadData1, PR_IDEX_ReadData2} !== {32'd5, 32'h1234}) begin
            fails++; $display("FAIL bypass_rt got=%h/%h exp=5/1234", PR_IDEX_ReadData1, PR_IDEX_ReadData2);
        end
        wb(1'b1, 5'd0, 32'hDEADBEEF);             // write to $0 while reading $0
        step();
        checks++; if ({PR_IDEX_ReadData1, PR_IDEX_ReadData2} !== 64'h0) begin
            fails++; $display("FAIL zero_reg_bypass got=%h/%h exp=0/0", PR_IDEX_ReadData1, PR_IDEX_ReadData2);
        end
        wb(1'b0, 5'd0, 32'd0);
        fetch(32'h0, 32'h18, 4'd6);
        step();
        checks++; if ({PR_IDEX_ReadData1, PR_IDEX_ReadData2} !== 64'h0) begin
            fails++; $display("FAIL zero_reg_stored got=%h/%h exp=0/0", PR_IDEX_ReadData1, PR_IDEX_ReadData2);
        end
    endtask

    task automatic test_stall();
        fetch(32'h00221820, 32'h20, 4'd6);        // ADD $3,$1,$2 into IF/ID
        step();
        fetch(32'h20040009, 32'h21, 4'd7);        // ADDI $4,$0,9 waits in fetch
        EX_MemRead = 1'b1; EX_Rt = 5'd2;
        #1;
        checks++; if (ID_Stall !== 1'b1) begin fails++; $display("FAIL stall_rt_src got=%b exp=1", ID_Stall); end
        step();
        checks++; if (idex_o !== '0) begin fails++; $display("FAIL stall_bubble got=%h exp=0", idex_o); end
        EX_MemRead = 1'b0;
        #1;
        checks++; if (ID_Stall !== 1'b0) begin fails++; $display("FAIL stall_release got=%b exp=0", ID_Stall); end
        step();
        checks++; if ({PR_IDEX_ReadData1, PR_IDEX_ReadData2, PR_IDEX_Rd, PR_IDEX_InstType, PR_IDEX_InstNum, PR_IDEX_NewPC}
                      !== {32'd5, 32'h1234, 5'd3, 4'd1, 4'd6, 32'h20}) begin
            fails++; $display("FAIL stall_held_add got=%h/%h rd=%0d type=%0d num=%0d pc=%h exp=5/1234 rd=3 type=1 num=6 pc=20",
                              PR_IDEX_ReadData1, PR_IDEX_ReadData2, PR_IDEX_Rd, PR_IDEX_InstType, PR_IDEX_InstNum, PR_IDEX_NewPC);
        end
        // ADDI in IF/ID: its rt is a destination, so a load into $4 must not stall.
        EX_MemRead = 1'b1; EX_Rt = 5'd4;
        fetch(32'h0, 32'h22, 4'd8);
        #1;
        checks++; if (ID_Stall !== 1'b0) begin fails++; $display("FAIL stall_rt_dest got=%b exp=0", ID_Stall); end
        step();
        checks++; if ({PR_IDEX_InstType, PR_IDEX_Rt, PR_IDEX_Imm, PR_IDEX_InstNum} !== {4'd2, 5'd4, 32'd9, 4'd7}) begin
            fails++; $display("FAIL stall_next_addi got=type%0d rt%0d imm%h num%0d exp=type2 rt4 imm9 num7",
                              PR_IDEX_InstType, PR_IDEX_Rt, PR_IDEX_Imm, PR_IDEX_InstNum);
        end
        // NOP in IF/ID, load into $0: never a hazard.
        EX_Rt = 5'd0;
        #1;
        checks++; if (ID_Stall !== 1'b0) begin fails++; $display("FAIL stall_rt_zero got=%b exp=0", ID_Stall); end
        EX_MemRead = 1'b0;
        step();
    endtask

    task automatic test_flush();
        fetch(32'h10220003, 32'h30, 4'd9);        // BEQ $1,$2,3
        step();
        fetch(32'h20040009, 32'h31, 4'd10);
        EX_MemRead = 1'b1; EX_Rt = 5'd1;
        #1;
        checks++; if (ID_Stall !== 1'b1) begin fails++; $display("FAIL flush_pre_hazard got=%b exp=1", ID_Stall); end
        Flush = 1'b1;
        #1;
        checks++; if (ID_Stall !== 1'b0) begin fails++; $display("FAIL flush_forces_stall_low got=%b exp=0", ID_Stall); end
        step();
        checks++; if (idex_o !== '0) begin fails++; $display("FAIL flush_idex_bubble got=%h exp=0", idex_o); end
        Flush = 1'b0; EX_MemRead = 1'b0; EX_Rt = 5'd0;
        fetch(32'h0, 32'h32, 4'd11);
        step();
        checks++; if (idex_o !== '0) begin fails++; $display("FAIL flush_ifid_bubble got=%h exp=0", idex_o); end
    endtask

    task automatic test_reset_mid();
        fetch(32'h2001FFFF, 32'h40, 4'd1); step();
        fetch(32'h00221820, 32'h41, 4'd2); step();
        fetch(32'h8C450004, 32'h42, 4'd3); step();   // LW $5,4($2)
        reset = 1'b1;
        wb(1'b1, 5'd5, 32'd99);                       // dropped by reset
        fetch(32'h00A51820, 32'h43, 4'd4);
        EX_MemRead = 1'b1; EX_Rt = 5'd2;              // LW in IF/ID would stall
        step();
        checks++; if (all_o !== '0) begin fails++; $display("FAIL reset_mid_outputs got=%h exp=0", all_o); end
        reset = 1'b0;
        idle_inputs();
        for (int i = 1; i < 32; i += 2) begin
            logic [4:0] a, b;
            a = 5'(i);
            b = 5'(i + 1);
            fetch({6'h00, a, b, 5'd3, 5'd0, 6'h20}, 32'h50, 4'd0);
            step();
            fetch(32'h0, 32'h51, 4'd0);
            step();
            checks++;
            if ({PR_IDEX_ReadData1, PR_IDEX_ReadData2} !== 64'h0) begin
                fails++;
                $display("FAIL reset_regs_r%0d_r%0d got=%h/%h exp=0/0", a, b, PR_IDEX_ReadData1, PR_IDEX_ReadData2);
            end
        end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [31:0] m_regs [32];
        logic [31:0] m_inst, m_newpc;
        logic [3:0]  m_num;
        bit          m_num_known;
        logic [31:0] e_rd1, e_rd2, e_imm, e_newpc;
        logic [20:0] e_fields;
        logic [8:0]  e_ctrl;
        logic [3:0]  e_type, e_num;
        bit          e_num_check, e_stall, hz, rst, fl, we, exmr;
        logic [4:0]  rs, rt, wreg, exrt;
        logic [31:0] wdata, inst, npc;
        logic [3:0]  num;
        int          cls;

        // Start from a known state shared by model and DUT.
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_inst = '0; m_newpc = '0; m_num = '0; m_num_known = 1'b1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            rst   = ($urandom_range(0, 59) == 0);
            fl    = ($urandom_range(0, 9) == 0);
            exmr  = ($urandom_range(0, 2) == 0);
            exrt  = 5'($urandom_range(0, 7));
            we    = $urandom_range(0, 1) == 1;
            wreg  = 5'($urandom_range(0, 7));
            wdata = $urandom;
            inst  = rand_inst();
            npc   = $urandom;
            num   = 4'($urandom);

            reset = rst; Flush = fl; EX_MemRead = exmr; EX_Rt = exrt;
            wb(we, wreg, wdata);
            fetch(inst, npc, num);
            #1;

            rs  = m_inst[25:21];
            rt  = m_inst[20:16];
            cls = classify(m_inst);
            hz  = exmr && exrt != 0 &&
                  (exrt == rs || (exrt == rt && (cls == 1 || cls == 4 || cls == 5)));
            e_stall = hz && !fl;
            checks++;
            if (ID_Stall !== e_stall) begin
                fails++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, ID_Stall, e_stall);
            end

            if (rst) begin
                e_ctrl = '0; e_type = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_newpc = '0;
                e_fields = '0; e_num = '0; e_num_check = 1'b1;
                for (int r = 0; r < 32; r++) m_regs[r] = '0;
                m_inst = '0; m_newpc = '0; m_num = '0; m_num_known = 1'b1;
            end else begin
                if (fl || e_stall) begin
                    e_ctrl = '0; e_type = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_newpc = '0;
                    e_fields = '0; e_num = '0; e_num_check = 1'b0;
                end else begin
                    e_ctrl   = exp_ctrl(cls);
                    e_type   = 4'(cls);
                    e_rd1    = (rs == 0) ? 32'h0 : (we && wreg == rs) ? wdata : m_regs[rs];
                    e_rd2    = (rt == 0) ? 32'h0 : (we && wreg == rt) ? wdata : m_regs[rt];
                    e_imm    = {{16{m_inst[15]}}, m_inst[15:0]};
                    e_newpc  = m_newpc;
                    e_fields = {rs, rt, m_inst[15:11], m_inst[5:0]};
                    e_num    = m_num;
                    e_num_check = m_num_known;
                end
                if (we && wreg != 0) m_regs[wreg] = wdata;
                if (fl) begin
                    m_inst = '0; m_newpc = '0; m_num_known = 1'b0;
                end else if (!e_stall) begin
                    m_inst = inst; m_newpc = npc; m_num = num; m_num_known = 1'b1;
                end
            end

            step();

            checks++;
            if (ctrl_o !== e_ctrl || PR_IDEX_InstType !== e_type) begin
                fails++; $display("FAIL rand_ctrl cyc=%0d got=%b/%0d exp=%b/%0d", cyc, ctrl_o, PR_IDEX_InstType, e_ctrl, e_type);
            end
            checks++;
            if (PR_IDEX_ReadData1 !== e_rd1 || PR_IDEX_ReadData2 !== e_rd2) begin
                fails++; $display("FAIL rand_operands cyc=%0d got=%h/%h exp=%h/%h", cyc, PR_IDEX_ReadData1, PR_IDEX_ReadData2, e_rd1, e_rd2);
            end
            checks++;
            if (PR_IDEX_Imm !== e_imm || PR_IDEX_NewPC !== e_newpc) begin
                fails++; $display("FAIL rand_imm_pc cyc=%0d got=%h/%h exp=%h/%h", cyc, PR_IDEX_Imm, PR_IDEX_NewPC, e_imm, e_newpc);
            end
            checks++;
            if ({PR_IDEX_Rs, PR_IDEX_Rt, PR_IDEX_Rd, PR_IDEX_Funct} !== e_fields) begin
                fails++; $display("FAIL rand_fields cyc=%0d got=%h exp=%h", cyc, {PR_IDEX_Rs, PR_IDEX_Rt, PR_IDEX_Rd, PR_IDEX_Funct}, e_fields);
            end
            if (e_num_check) begin
                checks++;
                if (PR_IDEX_InstNum !== e_num) begin
                    fails++; $display("FAIL rand_instnum cyc=%0d got=%0d exp=%0d", cyc, PR_IDEX_InstNum, e_num);
                end
            end
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_addi();
        test_add_wb();
        test_bypass();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/stage_id.md
Name: stage_id

Overview:
Instruction-decode stage of the five-stage MIPS32 pipeline, directly downstream of the fetch stage.
- Holds the IF/ID pipeline register.
- Decodes the instruction into control signals and reads/writes the 32x32 register file.
- Detects load-use hazards.
- Drives the ID/EX pipeline register consumed by the execute stage.

Parameters:
- REG_COUNT, 32, number of architectural registers (register 0 hardwired to zero)
- DATA_W, 32, register and datapath width

Ports:
- clock  in  1  single clock for the stage; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- IF_PC  in  32  word address of the fetched instruction
- IF_NewPC  in  32  PC+1 from fetch
- IF_Inst  in  32  fetched instruction word
- IF_InstNum  in  4  fetch sequence number, carried for display
- WB_RegWrite  in  1  write-back enable
- WB_WriteReg  in  5  write-back destination
- WB_WriteData  in  32  write-back data
- EX_MemRead  in  1  instruction currently in EX is a load
- EX_Rt  in  5  destination of that load
- Flush  in  1  taken branch resolved downstream; kill IF/ID and ID/EX contents
- ID_Stall  out  1  combinational; fetch must hold PC when high
- PR_IDEX_NewPC  out  32  latched PC+1
- PR_IDEX_ReadData1, PR_IDEX_ReadData2  out  32 each  rs/rt operand values
- PR_IDEX_Imm  out  32  sign-extended imm16
- PR_IDEX_Rs, PR_IDEX_Rt, PR_IDEX_Rd  out  5 each  register fields
- PR_IDEX_Funct  out  6  funct field
- CS_RegDst, CS_ALUSrc, CS_MemRead, CS_MemWrite, CS_MemToReg, CS_RegWrite, CS_Branch  out  1 each  latched controls
- CS_ALUOp  out  2  00 add, 01 sub, 10 use funct
- PR_IDEX_InstType  out  4  instruction class for display
- PR_IDEX_InstNum  out  4  carried sequence number

Behaviour:
- Reset clears IF/ID, ID/EX and all 32 registers to 0.
  - Every output is 0 after reset; InstType is INST_TYPE_NONE.
  - ID_Stall is 0 while the IF/ID register is empty.
- Latency: instruction on IF_* at edge n is captured into IF/ID. Its decoded result appears on the PR_IDEX_* and CS_* outputs after edge n+1.
- Decoded subset:
  - R-type (op 0): ADD, SUB, AND, OR, SLT. RegDst=1, RegWrite=1, ALUOp=10.
  - ADDI: ALUSrc=1, RegWrite=1, ALUOp=00.
  - LW: ALUSrc, MemRead, MemToReg, RegWrite; ALUOp=00.
  - SW: ALUSrc, MemWrite; ALUOp=00.
  - BEQ: Branch=1, ALUOp=01.
  - Any other opcode, including all-zero (NOP): all controls 0, InstType NONE.
- Register file:
  - Write occurs on the rising edge when WB_RegWrite is set and WB_WriteReg is nonzero.
  - Writes to register 0 are ignored; reads of register 0 return 0.
  - Same-cycle write/read of the same register bypasses, so the read returns WB_WriteData.
- Hazard: ID_Stall = EX_MemRead & (EX_Rt != 0) & ((EX_Rt == rs) | (EX_Rt == rt & rt is a source)). rt is a source for R-type, SW and BEQ.
- Stall cycle: IF/ID holds its value. ID/EX loads a bubble (all CS_* 0, InstType NONE, other fields 0).
- Flush: IF/ID and ID/EX both load bubbles on that edge.
  - Flush has priority over Stall.
  - ID_Stall is forced to 0 while Flush is high.
- Reset has priority over Flush and Stall.
  - Reset mid-stall discards the held instruction.
  - A write-back arriving in the same cycle as reset is dropped.
- Immediate: sign-extended from bit 15 for every opcode.
- InstNum passes IF/ID -> ID/EX unchanged. It is not replaced by bubble insertion; the next real instruction keeps its own number.

Decomposition:
- MIPS32 instruction-set include holds:
  - opcode and funct constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, FUNCT_ADD/SUB/AND/OR/SLT
  - ALUOp encodings
- Display-data include holds:
  - INST_TYPE_NONE=0, INST_TYPE_R=1, INST_TYPE_I=2, INST_TYPE_LOAD=3, INST_TYPE_STORE=4, INST_TYPE_BRANCH=5
- One sub-module, register_file: 2 read ports, 1 write port, zero register, write-through bypass.

Test Plan:
- Reset, then IF_Inst=0x2001FFFF (ADDI $1,$0,-1) -> after 2 edges: Imm=0xFFFFFFFF, Rt=1, ALUSrc=1, RegWrite=1, ReadData1=0, InstType=2.
- WB writes $1=5 and $2=7, then IF_Inst=0x00221820 (ADD $3,$1,$2) -> ReadData1=5, ReadData2=7, Rd=3, RegDst=1, ALUOp=10, Funct=0x20.
- WB_RegWrite=1, WB_WriteReg=2, WB_WriteData=0x1234 in the same cycle ID reads $2 -> ReadData2=0x1234; a write to register 0 leaves register 0 reading 0.
- IF/ID holds 0x00221820 with EX_MemRead=1, EX_Rt=2 -> ID_Stall=1 for that cycle, ID/EX bubble, IF/ID unchanged; with EX_MemRead=0 next cycle the ADD issues.
- Flush=1 with IF/ID holding BEQ 0x10220003 while EX_MemRead=1, EX_Rt=1 -> ID_Stall=0, both registers hold bubbles, all CS_* 0 on the next edge.
- Reset asserted mid-stream after three instructions -> next edge every output is 0 and registers $1..$31 read 0.
